dma_tx_frame_packer: RTL
========================

Name: dma_tx_frame_packer

Overview:
- Sits directly upstream of the DMA write path (addr/length/readNotWrite/start and data_in/ready_in pull interface).
- Accepts a byte-wide frame stream (valid/ready/last) and packs it little-endian into 32-bit words in an internal FIFO.
- Once a whole frame is buffered, issues one DMA write command of the exact byte length, then supplies words as the DMA pulls them.
- One frame buffered at a time.

Parameters:
- ADDR_W, 32, width of DMA address.
- LEN_W, 16, width of DMA byte length.
- DEPTH, 512, FIFO depth in 32-bit words; max frame = 4*DEPTH bytes; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_last  in  1  last byte of frame, qualified by s_valid
- s_ready  out  1  byte accepted when s_valid & s_ready
- cfg_addr  in  ADDR_W  destination byte address (any alignment)
- cfg_load  in  1  load address pointer (used only with optional feature)
- dma_addr  out  ADDR_W  to DMA addr
- dma_length  out  LEN_W  frame byte count
- dma_rnw  out  1  constant 0 (write)
- dma_start  out  1  one-cycle start pulse
- dma_ready  in  1  DMA idle
- dma_data  out  32  word to DMA data_in
- dma_ready_in  in  1  DMA pulls dma_data this cycle
- frames_sent  out  16  frames handed to DMA, wraps at 0xFFFF->0
- err_overflow  out  1  sticky: a frame exceeded 4*DEPTH bytes
- err_underflow  out  1  sticky: pull outside S_DRAIN

Behaviour:
- Reset values: s_ready=0, dma_addr=0, dma_length=0, dma_start=0, dma_data=0, frames_sent=0, both errors=0, FIFO empty, state S_RECV, byte lane=0, byte count=0. Async rst mid-frame or mid-drain discards all buffered data; no dma_start after release until a new frame completes.
- dma_rnw tied 0.
- States: S_RECV, S_WAIT, S_START, S_DRAIN.
- S_RECV:
  - s_ready=1 (except the cycle after reset release).
  - Each accepted byte goes to lane k (bits 8k+7:8k) of a pack register; byte count increments.
  - On lane 3, push the word (1-cycle latency to FIFO).
  - On s_last, push the partial word with unused upper lanes zero, then -> S_WAIT.
  - Byte count saturates at 4*DEPTH+1.
- Overflow:
  - Once byte count exceeds 4*DEPTH, further bytes are accepted and discarded.
  - At s_last: set err_overflow, flush FIFO, clear count, stay in S_RECV. No command issued.
- S_WAIT: s_ready=0. When dma_ready=1 -> S_START.
- S_START:
  - dma_start=1 for exactly one cycle.
  - dma_length = byte count, held stable until the next S_START.
  - dma_addr per address rule below.
  - -> S_DRAIN.
- S_DRAIN:
  - dma_data = FIFO head (show-ahead, combinational from head).
  - Each cycle with dma_ready_in=1 pops one word.
  - Pull with FIFO empty returns 0, is not an error, and covers extra pulls from unaligned addresses.
  - Exit when FIFO empty and dma_ready=1 and at least one cycle has passed since S_START: frames_sent++, clear count/lane, -> S_RECV.
- dma_ready_in=1 in any state other than S_DRAIN: set err_underflow, no pop, dma_data=0.
- Errors clear only on rst.
- Word count per frame = ceil(len/4), at most DEPTH. FIFO pointers are log2(DEPTH)+1 bits to distinguish full from empty.
- Address without feature: dma_addr <= cfg_addr sampled in S_START.

Optional Feature:
- Macro: DMA_TX_PACKER_ADDR_INC_EN.
- Defined:
  - Internal pointer loaded from cfg_addr on cfg_load, allowed in any state; it takes effect at the next S_START.
  - dma_addr <= pointer in S_START, then pointer += dma_length (mod 2^ADDR_W). Successive frames land contiguously.
  - cfg_load and S_START in the same cycle: load wins and is used for this frame, then incremented.
- Not defined: cfg_load ignored; dma_addr = cfg_addr sampled at S_START.

Test Plan:
- 8-byte frame 0x01..0x08, cfg_addr=0x1000, dma_ready=1 -> one dma_start pulse; dma_length=8; dma_addr=0x1000; pulls return 0x04030201 then 0x08070605; frames_sent=1.
- 5-byte frame 0xA0..0xA4, addr 0x1003 -> dma_length=5; words 0xA3A2A1A0, 0x000000A4; third pull returns 0 with err_underflow=0.
- dma_ready held 0 for 20 cycles after s_last -> s_ready=0 and no dma_start until dma_ready rises; dma_start occurs exactly one cycle later.
- DEPTH=4, 17-byte frame -> all 17 bytes accepted; err_overflow=1; no dma_start; a following 4-byte frame transfers normally.
- dma_ready_in pulsed in S_RECV -> err_underflow=1 (sticky); rst asserted mid-drain -> all outputs return to reset values, FIFO empty.
- With DMA_TX_PACKER_ADDR_INC_EN: cfg_load 0x2000, frames of 6 then 3 bytes -> dma_addr 0x2000 then 0x2006.

Source files
------------

// File: rtl/dma_tx_frame_packer.sv
// dma_tx_frame_packer: packs a byte frame stream little-endian into 32-bit words and hands each whole frame to the DMA as one write.
// Latency: byte to FIFO 1 cycle; dma_start 2 cycles after s_last if dma_ready; dma_data is show-ahead from the FIFO head.
// Backpressure: s_ready low from s_last until the frame is drained; DMA_TX_PACKER_ADDR_INC_EN enables the auto-incrementing address pointer.
module dma_tx_frame_packer #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic              cfg_load,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [LEN_W-1:0]  dma_length,
    output logic              dma_rnw,
    output logic              dma_start,
    input  logic              dma_ready,
    output logic [31:0]       dma_data,
    input  logic              dma_ready_in,
    output logic [15:0]       frames_sent,
    output logic              err_overflow,
    output logic              err_underflow
);
    localparam int MAX_BYTES = 4 * DEPTH;
    localparam int CNT_W     = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES + 1);

    typedef enum logic [1:0] {S_RECV, S_WAIT, S_START, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              ready_en_q;
    logic [1:0]        lane_q;
    logic [31:0]       pack_q;
    logic [31:0]       pack_nxt;
    logic [CNT_W-1:0]  byte_cnt_q;
    logic              push_vld_q;
    logic [31:0]       push_dat_q;
    logic              drain_seen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [15:0]       frames_q;
    logic              ovf_q, udf_q;

    logic              accept, drop, frame_done, frame_ovf, drain_exit;
    logic              fifo_pop, fifo_empty;
    logic [31:0]       fifo_head;

    assign accept     = s_valid && s_ready;
    assign drop       = byte_cnt_q >= CNT_LIM;
    assign frame_done = accept && s_last && !drop;
    assign frame_ovf  = accept && s_last && drop;
    assign drain_exit = (state_q == S_DRAIN) && fifo_empty && dma_ready && drain_seen_q;
    assign pack_nxt   = pack_q | ({24'd0, s_data} << {lane_q, 3'b000});

    assign dma_rnw       = 1'b0;
    assign dma_addr      = addr_q;
    assign dma_length    = len_q;
    assign frames_sent   = frames_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

    dma_tx_frame_packer_fifo #(
        .W     (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (frame_ovf),
        .wr_vld (push_vld_q),
        .wr_dat (push_dat_q),
        .rd_rdy (fifo_pop),
        .rd_dat (fifo_head),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RECV;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        dma_start = 1'b0;
        dma_data  = '0;
        fifo_pop  = 1'b0;
        case (state_q)
            S_RECV: begin
                s_ready = ready_en_q;
                if (frame_done) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dma_ready) state_d = S_START;
            end
            S_START: begin
                dma_start = 1'b1;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                // Pulls beyond the buffered words (unaligned destinations) read zero.
                if (!fifo_empty) begin
                    dma_data = fifo_head;
                    fifo_pop = dma_ready_in;
                end
                if (drain_exit) state_d = S_RECV;
            end
            default: state_d = S_RECV;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q       <= '0;
            pack_q       <= '0;
            byte_cnt_q   <= '0;
            push_vld_q   <= 1'b0;
            push_dat_q   <= '0;
            drain_seen_q <= 1'b0;
            len_q        <= '0;
            frames_q     <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            push_vld_q   <= 1'b0;
            drain_seen_q <= (state_q == S_DRAIN) && (state_d == S_DRAIN);
            if (accept) begin
                byte_cnt_q <= (byte_cnt_q == CNT_MAX) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);
                lane_q     <= lane_q + 2'd1;
                // Bytes past the buffer capacity are swallowed so the frame can be discarded whole.
                if (!drop) begin
                    if (lane_q == 2'd3 || s_last) begin
                        push_vld_q <= 1'b1;
                        push_dat_q <= pack_nxt;
                        pack_q     <= '0;
                    end else begin
                        pack_q <= pack_nxt;
                    end
                end
                if (s_last) lane_q <= '0;
                if (frame_ovf) begin
                    byte_cnt_q <= '0;
                    pack_q     <= '0;
                    ovf_q      <= 1'b1;
                end
            end
            if (state_q == S_START) len_q <= LEN_W'(byte_cnt_q);
            if (drain_exit) begin
                byte_cnt_q <= '0;
                lane_q     <= '0;
                frames_q   <= frames_q + 16'd1;
            end
            if (dma_ready_in && state_q != S_DRAIN) udf_q <= 1'b1;
        end
    end

`ifdef DMA_TX_PACKER_ADDR_INC_EN
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] base_addr;

    // A load in the start cycle overrides the running pointer for this very frame.
    assign base_addr = cfg_load ? cfg_addr : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            addr_q <= '0;
        end else if (state_q == S_START) begin
            addr_q <= base_addr;
            ptr_q  <= base_addr + ADDR_W'(LEN_W'(byte_cnt_q));
        end else if (cfg_load) begin
            ptr_q <= cfg_addr;
        end
    end
`else
    logic unused_cfg_load;
    assign unused_cfg_load = cfg_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (state_q == S_START) begin
            addr_q <= cfg_addr;
        end
    end
`endif

endmodule

// dma_tx_frame_packer_fifo: generic show-ahead word FIFO with synchronous flush.
// Latency: write visible at head the cycle after wr_vld; rd_dat is combinational from the head entry.
// Backpressure: writes when full and reads when empty are ignored; flush overrides both.
module dma_tx_frame_packer_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           full, do_wr, do_rd;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_wr  = wr_vld && !full && !flush;
    assign do_rd  = rd_rdy && !empty && !flush;
    assign rd_dat = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q[PTR_W-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule
